// File: rtl/board_renderer_pkg.sv
// tetris_pkg: board geometry, cell/colour types, palette and renderer states.
// Shared by the board renderer (grid overlay: BOARD_RENDERER_GRID_EN).
package tetris_pkg;

   localparam int BOARD_W = 10;
   localparam int BOARD_H = 20;

   typedef logic [2:0] cell_t;
   typedef enum logic [2:0] {EMPTY, I, O, T, S, Z, J, L} piece_e;

   typedef logic [5:0] colour_t;
   localparam colour_t COL_EMPTY   = 6'b000000;
   localparam colour_t COL_I       = 6'b001111;
   localparam colour_t COL_O       = 6'b111100;
   localparam colour_t COL_T       = 6'b100010;
   localparam colour_t COL_S       = 6'b001100;
   localparam colour_t COL_Z       = 6'b110000;
   localparam colour_t COL_J       = 6'b000011;
   localparam colour_t COL_L       = 6'b110100;
   localparam colour_t GRID_COLOUR = 6'b010101;

   typedef enum logic [2:0] {IDLE, FETCH, LATCH, PAINT, DONE} rstate_e;

   function automatic colour_t palette(cell_t c);
      case (piece_e'(c))
         I:       palette = COL_I;
         O:       palette = COL_O;
         T:       palette = COL_T;
         S:       palette = COL_S;
         Z:       palette = COL_Z;
         J:       palette = COL_J;
         L:       palette = COL_L;
         default: palette = COL_EMPTY;
      endcase
   endfunction

endpackage

// File: rtl/board_renderer_if.sv
// board_renderer_if: pixel-write port towards the vga_adapter.
// master drives the plot, slave (the adapter) consumes it.
interface board_renderer_if;
   logic [7:0] X;
   logic [6:0] Y;
   logic [5:0] colour;
   logic       writeEn;

   modport master (output X, output Y, output colour, output writeEn);
   modport slave  (input X, input Y, input colour, input writeEn);
endinterface

// File: rtl/board_renderer.sv
// board_renderer: redraws the 10x20 board as 5x5 pixel squares on a start pulse.
// Define BOARD_RENDERER_GRID_EN to outline empty cells in GRID_COLOUR.
module board_renderer
   import tetris_pkg::*;
#(
   parameter int CELL_PX  = 5,
   parameter int ORIGIN_X = 55,
   parameter int ORIGIN_Y = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [7:0]        rd_addr,
   input  logic [2:0]        rd_data,
   board_renderer_if.master  vga,
   output logic              busy,
   output logic              done
);

   localparam logic [2:0] PX_LAST  = 3'(CELL_PX - 1);
   localparam logic [3:0] COL_LAST = 4'(BOARD_W - 1);
   localparam logic [4:0] ROW_LAST = 5'(BOARD_H - 1);

   rstate_e    state_q, state_d;
   logic [7:0] rd_addr_q, rd_addr_d;
   logic [4:0] row_q, row_d;
   logic [3:0] col_q, col_d;
   logic [2:0] px_q, px_d;
   logic [2:0] py_q, py_d;
   cell_t      cell_q, cell_d;
   logic [7:0] x_q, x_d;
   logic [6:0] y_q, y_d;
   colour_t    colour_q, colour_d;
   logic       we_q, we_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   cell_t      pix_cell;

   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      row_d     = row_q;
      col_d     = col_q;
      px_d      = px_q;
      py_d      = py_q;
      cell_d    = cell_q;
      x_d       = x_q;
      y_d       = y_q;
      colour_d  = colour_q;
      we_d      = 1'b0;
      pix_cell  = cell_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = FETCH;
               rd_addr_d = 8'd0;
               row_d     = 5'd0;
               col_d     = 4'd0;
               px_d      = 3'd0;
               py_d      = 3'd0;
            end
         end
         FETCH: state_d = LATCH;
         LATCH: begin
            // rd_data is consumed directly so the first plot is registered now
            state_d  = PAINT;
            cell_d   = rd_data;
            pix_cell = rd_data;
            px_d     = 3'd0;
            py_d     = 3'd0;
            we_d     = 1'b1;
         end
         PAINT: begin
            if (px_q == PX_LAST && py_q == PX_LAST) begin
               px_d = 3'd0;
               py_d = 3'd0;
               if (row_q == ROW_LAST && col_q == COL_LAST) begin
                  state_d   = DONE;
                  rd_addr_d = 8'd0;
                  row_d     = 5'd0;
                  col_d     = 4'd0;
               end else begin
                  state_d   = FETCH;
                  rd_addr_d = rd_addr_q + 8'd1;
                  if (col_q == COL_LAST) begin
                     col_d = 4'd0;
                     row_d = row_q + 5'd1;
                  end else begin
                     col_d = col_q + 4'd1;
                  end
               end
            end else begin
               we_d = 1'b1;
               if (px_q == PX_LAST) begin
                  px_d = 3'd0;
                  py_d = py_q + 3'd1;
               end else begin
                  px_d = px_q + 3'd1;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (we_d) begin
         x_d = 8'(ORIGIN_X + CELL_PX * int'(col_q) + int'(px_d));
         y_d = 7'(ORIGIN_Y + CELL_PX * int'(row_q) + int'(py_d));
         colour_d = palette(pix_cell);
`ifdef BOARD_RENDERER_GRID_EN
         if (pix_cell == cell_t'(EMPTY) &&
             (px_d == PX_LAST || py_d == PX_LAST))
            colour_d = GRID_COLOUR;
`endif
      end

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         rd_addr_q <= 8'd0;
         row_q     <= 5'd0;
         col_q     <= 4'd0;
         px_q      <= 3'd0;
         py_q      <= 3'd0;
         cell_q    <= '0;
         x_q       <= 8'd0;
         y_q       <= 7'd0;
         colour_q  <= '0;
         we_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_addr_q <= rd_addr_d;
         row_q     <= row_d;
         col_q     <= col_d;
         px_q      <= px_d;
         py_q      <= py_d;
         cell_q    <= cell_d;
         x_q       <= x_d;
         y_q       <= y_d;
         colour_q  <= colour_d;
         we_q      <= we_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign rd_addr     = rd_addr_q;
   assign vga.X       = x_q;
   assign vga.Y       = y_q;
   assign vga.colour  = colour_q;
   assign vga.writeEn = we_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: doc/board_renderer.md
Name: board_renderer

Overview:
- Walks the 10x20 playfield occupancy memory cell by cell.
- For every cell it emits one plot per pixel of a 5x5 square (X, Y, colour, writeEn), which drives the vga_adapter pixel-write port at 160x120.
- Sits between the game control/board storage and the VGA adapter; a start pulse triggers one full-board redraw.

Parameters:
- BOARD_W, 10, cells per row
- BOARD_H, 20, cells per column
- CELL_PX, 5, pixel edge length of one cell
- ORIGIN_X, 55, screen X of the board's left edge
- ORIGIN_Y, 10, screen Y of the board's top edge

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high reset
- start  in  1  request one full redraw; sampled only in IDLE
- rd_addr  out  8  board memory address = row*BOARD_W + col
- rd_data  in  3  cell type; 0=empty, 1..7 = I,O,T,S,Z,J,L; valid one cycle after rd_addr is presented
- X  out  8  pixel x to vga_adapter
- Y  out  7  pixel y to vga_adapter
- colour  out  6  RRGGBB pixel colour
- writeEn  out  1  plot strobe
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the redraw completes

Behaviour:
- Reset: state=IDLE; X=0, Y=0, colour=0, writeEn=0, rd_addr=0, busy=0, done=0; row, col and pixel counters cleared.
- Reset asserted mid-frame aborts the redraw immediately; no further writeEn is produced.
- All outputs are registered.
- States: IDLE -> FETCH -> LATCH -> PAINT -> (FETCH | DONE) -> IDLE.
- IDLE: if start=1 at edge N, state is FETCH at N+1 with rd_addr=0.
- start while busy is ignored (no queuing).
- FETCH (1 cycle): rd_addr holds the current cell address.
- LATCH (1 cycle): rd_data is captured into cell_q.
- PAINT (CELL_PX*CELL_PX = 25 cycles): writeEn=1 on every cycle.
  - X = ORIGIN_X + col*CELL_PX + px; Y = ORIGIN_Y + row*CELL_PX + py.
  - px runs 0..4 fastest, then py 0..4.
  - colour = palette(cell_q).
- End of cell: after py=px=4, advance col. When col wraps at BOARD_W-1, col resets to 0 and row increments.
  - After cell 199 (row 19, col 9): go to DONE; otherwise go to FETCH.
- DONE (1 cycle): done=1, busy=1, writeEn=0; then IDLE.
- Timing: first writeEn at N+3. 27 cycles per cell; 5400 cycles for the board. done asserted at cycle N+5401.
- writeEn is 0 in IDLE, FETCH, LATCH and DONE.
- Width rules: X max = 55+49 = 104, Y max = 10+99 = 109; both fit without overflow.
- Coordinate adders are sized to 8 and 7 bits respectively. rd_addr max = 199.
- Palette:
  - 0 -> 000000
  - I -> 001111
  - O -> 111100
  - T -> 100010
  - S -> 001100
  - Z -> 110000
  - J -> 000011
  - L -> 110100

Optional Feature:
- Macro: BOARD_RENDERER_GRID_EN.
- Defined: for empty cells (cell_q=0), pixels with px=CELL_PX-1 or py=CELL_PX-1 are drawn in grid colour 010101; all other pixels stay 000000. Filled cells are unaffected.
- Undefined: empty cells are drawn entirely 000000. Timing is identical in both builds.

Decomposition:
- Package tetris_pkg holds:
  - board dimension constants (BOARD_W, BOARD_H)
  - 3-bit cell_t typedef and piece enum (EMPTY, I, O, T, S, Z, J, L)
  - 6-bit colour_t typedef, palette constants and GRID_COLOUR
  - palette lookup function
  - renderer state enum
- No sub-module is needed; the raster counters and FSM stay in one module.

Test Plan:
- Reset held 3 cycles, then released with start=0 -> all outputs 0; state remains IDLE indefinitely.
- All-empty board, start pulse at cycle N -> exactly 5000 writeEn cycles, all colour=000000; first at N+3; done at N+5401 for one cycle; busy falls the cycle after done.
- rd_data=3 (T) at addr 0 only -> the 25 pixels X 55..59, Y 10..14 are 100010; the next cell's pixels (X 60..64) are 000000.
- rd_data=1 (I) at addr 199 only -> the last 25 plots are X 100..104, Y 105..109, colour 001111, in row-major pixel order.
- start re-pulsed at cycle N+100, then reset asserted at N+200 -> the re-pulse has no effect; writeEn=0 from N+201 and state=IDLE; a new start performs a complete fresh redraw from addr 0.
- With BOARD_RENDERER_GRID_EN and an empty board -> per cell, 9 pixels are 010101 and 16 pixels are 000000; a filled Z cell is all 110000.
